// File: rtl/alu_pipe2.sv
// alu_pipe2: two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 resolves the low LO_WIDTH bits of add/sub and registers the carry;
// stage 2 resolves the high bits and holds the result for the consumer.
// Optional flags output enabled by defining ALU_PIPE_FLAGS_EN.
module alu_pipe2 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LO_WIDTH  = WIDTH / 2,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_mode,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]           out_flags
`endif
);

  localparam int unsigned HI_WIDTH = WIDTH - LO_WIDTH;

  localparam logic [3:0] MODE_AND   = 4'd0;
  localparam logic [3:0] MODE_OR    = 4'd1;
  localparam logic [3:0] MODE_ADD   = 4'd2;
  localparam logic [3:0] MODE_SLTU  = 4'd5;
  localparam logic [3:0] MODE_SUB   = 4'd6;
  localparam logic [3:0] MODE_SLT   = 4'd7;
  localparam logic [3:0] MODE_XOR   = 4'd8;
  localparam logic [3:0] MODE_CSRRS = 4'd10;
  localparam logic [3:0] MODE_CSRRC = 4'd11;

  // Stage 1 state
  logic                 s1_valid_q;
  logic [3:0]           mode_q,  mode_d;
  logic [TAG_WIDTH-1:0] tag_q,   tag_d;
  logic [HI_WIDTH-1:0]  a_hi_q,  a_hi_d;
  logic [HI_WIDTH-1:0]  b_hi_q,  b_hi_d;
  logic [LO_WIDTH-1:0]  lo_q,    lo_d;
  logic                 c_q,     c_d;

  // Stage 2 state
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_result_q, result_d;
  logic [TAG_WIDTH-1:0] out_tag_q;

  logic                 s1_load_c;
  logic                 s2_load_c;
  logic                 sub_op_c;
  logic [WIDTH-1:0]     b_eff_c;
  logic [LO_WIDTH:0]    lo_sum_c;
  logic [HI_WIDTH:0]    hi_sum_c;
  logic [HI_WIDTH-1:0]  hi_res_c;
  logic                 ovf_c;
  logic                 lt_c;

  // Pipeline advance: stage 2 frees when empty or drained, stage 1 follows it
  always_comb begin
    s2_load_c = !out_valid_q || out_ready;
    s1_load_c = !s1_valid_q || s2_load_c;
    in_ready  = s1_load_c;
  end

  // Stage 1: invert B for subtract-type ops, resolve the low slice and its carry
  always_comb begin
    sub_op_c = (in_mode == MODE_SUB) || (in_mode == MODE_SLT) || (in_mode == MODE_SLTU);
    b_eff_c  = sub_op_c ? ~in_b : in_b;
    lo_sum_c = (LO_WIDTH+1)'(in_a[LO_WIDTH-1:0]) + (LO_WIDTH+1)'(b_eff_c[LO_WIDTH-1:0])
             + (LO_WIDTH+1)'(sub_op_c);
    lo_d     = '0;
    case (in_mode)
      MODE_AND:                                lo_d = in_a[LO_WIDTH-1:0] & in_b[LO_WIDTH-1:0];
      MODE_OR, MODE_CSRRS:                     lo_d = in_a[LO_WIDTH-1:0] | in_b[LO_WIDTH-1:0];
      MODE_XOR:                                lo_d = in_a[LO_WIDTH-1:0] ^ in_b[LO_WIDTH-1:0];
      MODE_CSRRC:                              lo_d = ~in_a[LO_WIDTH-1:0] & in_b[LO_WIDTH-1:0];
      MODE_ADD, MODE_SUB, MODE_SLT, MODE_SLTU: lo_d = lo_sum_c[LO_WIDTH-1:0];
      default:                                 lo_d = '0;
    endcase
    c_d    = lo_sum_c[LO_WIDTH];
    mode_d = in_mode;
    tag_d  = in_tag;
    a_hi_d = in_a[WIDTH-1:LO_WIDTH];
    b_hi_d = b_eff_c[WIDTH-1:LO_WIDTH];
  end

  // Stage 1 data registers; only the valid bit needs reset
  always_ff @(posedge clk) begin
    if (s1_load_c && in_valid) begin
      mode_q <= mode_d;
      tag_q  <= tag_d;
      a_hi_q <= a_hi_d;
      b_hi_q <= b_hi_d;
      lo_q   <= lo_d;
      c_q    <= c_d;
    end
  end

  // Stage 2: finish the high slice with the registered carry and select the result
  always_comb begin
    hi_sum_c = (HI_WIDTH+1)'(a_hi_q) + (HI_WIDTH+1)'(b_hi_q) + (HI_WIDTH+1)'(c_q);
    ovf_c    = (a_hi_q[HI_WIDTH-1] == b_hi_q[HI_WIDTH-1]) &&
               (hi_sum_c[HI_WIDTH-1] != a_hi_q[HI_WIDTH-1]);
    lt_c     = (mode_q == MODE_SLT) ? (hi_sum_c[HI_WIDTH-1] ^ ovf_c) : !hi_sum_c[HI_WIDTH];
    hi_res_c = '0;
    case (mode_q)
      MODE_AND:            hi_res_c = a_hi_q & b_hi_q;
      MODE_OR, MODE_CSRRS: hi_res_c = a_hi_q | b_hi_q;
      MODE_XOR:            hi_res_c = a_hi_q ^ b_hi_q;
      MODE_CSRRC:          hi_res_c = ~a_hi_q & b_hi_q;
      MODE_ADD, MODE_SUB:  hi_res_c = hi_sum_c[HI_WIDTH-1:0];
      default:             hi_res_c = '0;
    endcase
    if ((mode_q == MODE_SLT) || (mode_q == MODE_SLTU)) begin
      result_d = WIDTH'(lt_c);
    end else begin
      result_d = {hi_res_c, lo_q};
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] out_flags_q;
  logic [3:0] flags_d;

  // Flags {N, Z, C, V} computed from the stage-2 result and adder
  always_comb begin
    flags_d    = 4'b0000;
    flags_d[3] = result_d[WIDTH-1];
    flags_d[2] = (result_d == '0);
    if ((mode_q == MODE_ADD) || (mode_q == MODE_SUB) ||
        (mode_q == MODE_SLT) || (mode_q == MODE_SLTU)) begin
      flags_d[1] = hi_sum_c[HI_WIDTH];
    end
    if ((mode_q == MODE_ADD) || (mode_q == MODE_SUB)) begin
      flags_d[0] = ovf_c;
    end
  end

  // Flags register loads together with the result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags_q <= 4'b0000;
    end else if (s2_load_c && s1_valid_q) begin
      out_flags_q <= flags_d;
    end
  end

  assign out_flags = out_flags_q;
`else
  // Flags output not built in this configuration
`endif

  // Valid bits and output registers; a handshake during reset is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      if (s1_load_c) begin
        s1_valid_q <= in_valid;
      end
      if (s2_load_c) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q <= result_d;
          out_tag_q    <= tag_q;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_pipe2.sv
// Directed self-checking bench for alu_pipe2 (WIDTH=32, LO_WIDTH=16).
module tb_alu_pipe2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  int checks = 0;
  int errors = 0;

  alu_pipe2 #(.WIDTH(32), .LO_WIDTH(16), .TAG_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // One op through an empty pipe with out_ready=1; ends one cycle after delivery
  task automatic run_op(input string name, input logic [3:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, " valid@1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, " valid@2"}, 32'(out_valid), 32'd1);
    check({name, " result"}, out_result, exp);
    check({name, " tag"}, 32'(out_tag), 32'(tag));
    @(posedge clk); #1;
  endtask

  int          sent;
  int          got;
  int          occ;
  logic        acc_in;
  logic        acc_out;
  logic        prev_stall;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;

  initial begin
    // Reset with an op driven during reset
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 4'd2;
    in_a      = 32'h1234_5678;
    in_b      = 32'h1111_1111;
    in_tag    = 5'd9;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_result", out_result, 32'd0);
    check("rst out_tag", 32'(out_tag), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst no ghost op", 32'(out_valid), 32'd0);

    // Carry across the split and subtract borrow
    run_op("add carry", 4'd2, 32'h0000_FFFF, 32'h0000_0001, 5'd3, 32'h0001_0000);
    run_op("sub 0-1",   4'd6, 32'h0000_0000, 32'h0000_0001, 5'd4, 32'hFFFF_FFFF);
`ifdef ALU_PIPE_FLAGS_EN
    run_op("add ovf",   4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd1, 32'h8000_0000);
    check("flags add ovf", 32'(out_flags), 32'h9);
    run_op("sub 3-3",   4'd6, 32'd3, 32'd3, 5'd2, 32'd0);
    check("flags sub zero", 32'(out_flags), 32'h6);
`endif

    // Compares
    run_op("slt -1,1",   4'd7, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1);
    run_op("sltu max,1", 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0);
    run_op("slt min,max",4'd7, 32'h8000_0000, 32'h7FFF_FFFF, 5'd7, 32'd1);
    run_op("slt 5,5",    4'd7, 32'd5, 32'd5, 5'd8, 32'd0);

    // Logic / CSR / unused codes
    run_op("and",    4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 32'hF000_F000);
    run_op("or",     4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 32'hFFF0_FFF0);
    run_op("xor",    4'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd12, 32'h0FF0_0FF0);
    run_op("csrrs",  4'd10, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'hFFF0_FFF0);
    run_op("csrrc",  4'd11, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd14, 32'h0F00_0F00);
    run_op("mode15", 4'd15, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd15, 32'd0);
    run_op("mode3",  4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'd0);

    // Back-pressure stream: 8 ADDs i+i, out_ready pattern 1,0,0,1 repeating
    sent       = 0;
    got        = 0;
    occ        = 0;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_tag   = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      in_valid  = (sent < 8);
      in_mode   = 4'd2;
      in_a      = 32'(sent);
      in_b      = 32'(sent);
      in_tag    = 5'(sent);
      #1;
      check("bp in_ready", 32'(in_ready), 32'(!((occ == 2) && !out_ready)));
      if (prev_stall) begin
        check("bp held valid", 32'(out_valid), 32'd1);
        check("bp held result", out_result, prev_res);
        check("bp held tag", 32'(out_tag), 32'(prev_tag));
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        check("bp result", out_result, 32'(2 * got));
        check("bp tag", 32'(out_tag), 32'(got));
        got++;
      end
      occ        = occ + int'(acc_in) - int'(acc_out);
      sent       = sent + int'(acc_in);
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp received count", 32'(got), 32'd8);
    check("bp drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
